// File: rtl/keypad_key_driver_if.sv
// Handshake and key-bus bundle between a digit source and the keypad key driver.
interface keypad_key_driver_if;
    logic [3:0] code;
    logic       valid;
    logic       ready;
    logic       cancel;
    logic [9:0] keys;
    logic       pressed;
    logic       done;
    logic       err;
    logic [7:0] sent;

    modport master (
        output code, valid, cancel,
        input  ready, keys, pressed, done, err, sent
    );

    modport slave (
        input  code, valid, cancel,
        output ready, keys, pressed, done, err, sent
    );
endinterface

// File: rtl/keypad_key_driver.sv
// Emulates physical key presses on a one-hot 10-line key bus from digit codes
// accepted over valid/ready, with programmable hold and release times.
module keypad_key_driver #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input logic                 clk,
    input logic                 rst,
    keypad_key_driver_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [9:0] keys_q;
    logic       pressed_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            keys_q    <= '0;
            pressed_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sent_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    // cancel has no meaning here; a concurrent handshake wins
                    if (bus.valid) begin
                        if (bus.code <= 4'd9) begin
                            state_q   <= StHold;
                            keys_q    <= 10'(1) << bus.code;
                            pressed_q <= 1'b1;
                            cnt_q     <= 8'(HOLD_CYCLES - 1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (bus.cancel) begin
                        state_q   <= StIdle;
                        keys_q    <= '0;
                        pressed_q <= 1'b0;
                    end else if (cnt_q == 8'd0) begin
                        state_q   <= StGap;
                        keys_q    <= '0;
                        pressed_q <= 1'b0;
                        cnt_q     <= 8'(GAP_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (bus.cancel) begin
                        state_q <= StIdle;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        sent_q  <= sent_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    keys_q    <= '0;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = (state_q == StIdle);
    assign bus.keys    = keys_q;
    assign bus.pressed = pressed_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.sent    = sent_q;

endmodule

// File: tb/tb_keypad_key_driver.sv
// Directed bench for keypad_key_driver with a keystroke scoreboard and per-cycle bus checks.
module tb_keypad_key_driver;

    logic clk;
    logic rst;

    keypad_key_driver_if bus ();

    keypad_key_driver #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         passed;
    int         fails;
    int         cyc;
    int         done_cnt;
    int         hs_cyc;
    logic       prev_pressed;
    logic       exp_err;
    logic [7:0] model_sent;
    logic [9:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample away from the edge and score the bus.
    task automatic tick();
        logic [9:0] front;
        @(posedge clk);
        #1;
        cyc++;
        check("onehot", 32'($countones(bus.keys) <= 1), 32'd1);
        check("pressed_or", 32'(bus.pressed), 32'(|bus.keys));
        check("err_pulse", 32'(bus.err), 32'(exp_err));
        exp_err = 1'b0;
        if (bus.done) check("done_err_excl", 32'(bus.err), 32'd0);
        if (bus.pressed && !prev_pressed) begin
            check("sb_press_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                front = sb[0];
                check("sb_keys", 32'(bus.keys), 32'(front));
            end
        end
        if (bus.done) begin
            done_cnt++;
            model_sent = model_sent + 8'd1;
            check("sb_done_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
            check("sb_sent", 32'(bus.sent), 32'(model_sent));
        end
        prev_pressed = bus.pressed;
    endtask

    // Offer a code and return just after the handshake edge.
    task automatic offer(input logic [3:0] c);
        int waited;
        bit ok;
        bus.code  = c;
        bus.valid = 1'b1;
        waited    = 0;
        ok        = 1'b0;
        while (!ok && waited < 50) begin
            if (bus.ready) begin
                if (c <= 4'd9) sb.push_back(10'(1) << c);
                else exp_err = 1'b1;
                hs_cyc = cyc;
                ok     = 1'b1;
            end
            tick();
            waited++;
        end
        bus.valid = 1'b0;
        check("handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        int start;
        int waited;
        start  = done_cnt;
        waited = 0;
        while (done_cnt == start && waited < 50) begin
            tick();
            waited++;
        end
        check("done_timeout", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        model_sent = '0;
    endtask

    initial begin
        int start_done;
        int h0;
        total        = 0;
        passed       = 0;
        fails        = 0;
        cyc          = 0;
        done_cnt     = 0;
        prev_pressed = 1'b0;
        exp_err      = 1'b0;
        model_sent   = '0;
        bus.code     = 4'd0;
        bus.valid    = 1'b0;
        bus.cancel   = 1'b0;
        do_reset();

        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_keys", 32'(bus.keys), 32'd0);
        check("rst_pressed", 32'(bus.pressed), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sent", 32'(bus.sent), 32'd0);

        // Single keystroke, exact hold/gap timing.
        offer(4'd3);
        bus.code = 4'd6;
        check("t1_ready_low", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t1_hold_keys", 32'(bus.keys), 32'h008);
            check("t1_hold_pressed", 32'(bus.pressed), 32'd1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            check("t1_gap_keys", 32'(bus.keys), 32'd0);
            check("t1_gap_done", 32'(bus.done), 32'd0);
            tick();
        end
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_sent", 32'(bus.sent), 32'd1);
        check("t1_ready", 32'(bus.ready), 32'd1);
        tick();
        check("t1_done_pulse", 32'(bus.done), 32'd0);

        // Back-to-back 0 then 9 with valid held high.
        start_done = done_cnt;
        offer(4'd0);
        h0 = hs_cyc;
        for (int i = 0; i < 4; i++) begin
            check("t2_keys0", 32'(bus.keys), 32'h001);
            tick();
        end
        tick();
        tick();
        offer(4'd9);
        check("t2_period", 32'(hs_cyc - h0), 32'd7);
        check("t2_keys9", 32'(bus.keys), 32'h200);
        wait_done();
        check("t2_done_count", 32'(done_cnt - start_done), 32'd2);
        check("t2_sent", 32'(bus.sent), 32'd3);

        // Illegal code then a legal one on the next cycle.
        offer(4'd12);
        check("t3_err", 32'(bus.err), 32'd1);
        check("t3_keys", 32'(bus.keys), 32'd0);
        check("t3_ready", 32'(bus.ready), 32'd1);
        check("t3_sent", 32'(bus.sent), 32'd3);
        offer(4'd5);
        check("t3_accept_next", 32'(hs_cyc), 32'(cyc - 1));
        check("t3_keys5", 32'(bus.keys), 32'h020);
        wait_done();

        // Cancel in the 2nd hold cycle.
        start_done = done_cnt;
        offer(4'd7);
        tick();
        check("t4_hold_keys", 32'(bus.keys), 32'h080);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        void'(sb.pop_front());
        check("t4_keys", 32'(bus.keys), 32'd0);
        check("t4_pressed", 32'(bus.pressed), 32'd0);
        check("t4_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        check("t4_no_done", 32'(done_cnt - start_done), 32'd0);
        check("t4_sent", 32'(bus.sent), 32'(model_sent));

        // Cancel in the first gap cycle.
        offer(4'd7);
        for (int i = 0; i < 4; i++) tick();
        check("t4g_gap_keys", 32'(bus.keys), 32'd0);
        check("t4g_gap_ready", 32'(bus.ready), 32'd0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        void'(sb.pop_front());
        check("t4g_ready", 32'(bus.ready), 32'd1);
        check("t4g_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("t4g_no_done", 32'(done_cnt - start_done), 32'd0);
        check("t4g_sent", 32'(bus.sent), 32'(model_sent));

        // Cancel together with valid in idle is ignored.
        bus.cancel = 1'b1;
        offer(4'd2);
        bus.cancel = 1'b0;
        check("t4i_keys", 32'(bus.keys), 32'h004);
        wait_done();

        // Reset mid-hold.
        offer(4'd4);
        tick();
        check("t5_keys_before", 32'(bus.keys), 32'h010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model_sent = '0;
        check("t5_keys", 32'(bus.keys), 32'd0);
        check("t5_pressed", 32'(bus.pressed), 32'd0);
        check("t5_sent", 32'(bus.sent), 32'd0);
        check("t5_ready", 32'(bus.ready), 32'd1);

        // Wrap of the completed-keystroke counter.
        for (int i = 0; i < 256; i++) begin
            offer(4'(i % 10));
            wait_done();
            if (i == 254) check("t6_sent_255", 32'(bus.sent), 32'd255);
        end
        check("t6_sent_wrap", 32'(bus.sent), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/keypad_key_driver.md
Name: keypad_key_driver

Overview:
- Transmit-side counterpart of the team's 10-key keypad decoder.
- Takes digit codes over a valid/ready handshake and drives a one-hot 10-line key bus, emulating a physical key press with programmable hold and release times.
- Used as the stimulus/emulation source feeding the keypad decoder path, and for automated keypad entry on the board.
- Key line k represents digit k (k = 0..9); only one line is ever high.

Parameters:
HOLD_CYCLES  4  cycles a key line stays asserted per keystroke (legal range 1..255)
GAP_CYCLES   2  cycles all lines stay low after release before the next keystroke is accepted (legal range 1..255)

Ports:
clk      input   1   system clock, all logic on rising edge
rst      input   1   synchronous, active-high reset
code     input   4   digit to press, 0..9; 10..15 are illegal
valid    input   1   code is offered this cycle
ready    output  1   driver can accept a code this cycle
cancel   input   1   synchronous abort of the keystroke in progress
keys     output  10  one-hot key lines; keys[k]=1 means digit k is pressed
pressed  output  1   OR-reduction of keys, registered together with keys
done     output  1   one-cycle pulse: keystroke fully completed (hold and gap)
err      output  1   one-cycle pulse: illegal code was accepted and discarded
sent     output  8   count of completed keystrokes, wraps 255 -> 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, keys=0, pressed=0, done=0, err=0, sent=0, ready=1 in the cycle after rst is sampled high. rst overrides all other inputs, including in mid-keystroke; the lines drop to 0 immediately on the next edge.
- States: IDLE, HOLD, GAP. Outputs are registered; ready=1 only in IDLE; ready is combinational from state.
- IDLE: a handshake occurs on an edge where valid=1 and ready=1.
  - code 0..9: next cycle state=HOLD, keys=1<<code, pressed=1, counter=HOLD_CYCLES-1.
  - code 10..15: next cycle err=1 for exactly one cycle; state stays IDLE, keys stay 0, sent unchanged, ready stays 1.
- HOLD: keys are held constant for exactly HOLD_CYCLES cycles. The counter decrements each cycle. When the counter is 0: next state=GAP, keys=0, pressed=0, counter=GAP_CYCLES-1.
- GAP: keys=0 for exactly GAP_CYCLES cycles. When the counter is 0: next state=IDLE, done=1 for one cycle, sent=sent+1 (8-bit wrap), all in the same cycle.
- Minimum keystroke period is 1+HOLD_CYCLES+GAP_CYCLES cycles (handshake cycle + hold + gap).
- cancel:
  - In HOLD or GAP: next cycle state=IDLE, keys=0, pressed=0, no done, sent unchanged.
  - In IDLE: no effect.
  - cancel together with valid in IDLE: the handshake proceeds; cancel is ignored.
- valid while ready=0 is ignored. The code is not queued; the source must hold it.
- code is sampled only on the handshake edge. Later changes to code do not alter keys.
- keys never has more than one bit set. pressed == |keys in every cycle.
- done and err never assert in the same cycle.

Test Plan:
- Reset then code=3, valid=1 for one cycle -> ready drops; keys=10'b0000001000 and pressed=1 for 4 cycles; then keys=0 for 2 cycles; then done=1 for 1 cycle, sent=1, ready=1.
- Back-to-back codes 0 then 9 with valid held high -> keys=0x001 for 4 cycles, then 2 gap cycles, then accept, then keys=0x200 for 4 cycles; done pulses twice; sent=2; 7-cycle keystroke period.
- code=12 with valid=1 -> err=1 for 1 cycle; keys stay 0; ready stays 1; sent unchanged; a following code=5 is accepted on the next cycle.
- cancel asserted in the 2nd HOLD cycle of code=7 -> keys=0 on the next cycle; state IDLE; no done; sent unchanged. The same test with cancel in GAP gives the same result.
- rst asserted mid-HOLD with keys=0x010 -> next cycle keys=0, pressed=0, sent=0, ready=1.
- 256 legal keystrokes -> sent wraps from 255 to 0 on the 256th done pulse. At no cycle does keys have more than one bit set.
